div_share_arbiter: RTL and testbench

DIV_SHARE_ARBITER -- requirements
Module: div_share_arbiter

---
 rtl/div_share_arbiter.sv | 92 +++++++++
 tb/tb_div_share_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/div_share_arbiter.sv
// div_share_arbiter: round-robin share of one divider between two requesters; DIV_ZERO_CHECK_EN answers b == 0 locally.
module div_share_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             ack0,
  output logic             ack1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] quot_out,
  output logic [WIDTH-1:0] rem_out,
  output logic             err_out,
  output logic             div_start,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder,
  input  logic             div_busy,
  input  logic             div_done
);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
`ifdef DIV_ZERO_CHECK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif
  logic [1:0] state;
  logic ptr, gnt, zpend, sel, sel_zero;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic unused_ok;
  assign unused_ok = div_busy;
  always_comb begin
    sel = (req0 && req1) ? ptr : req1;
    sel_a = sel ? a1 : a0;
    sel_b = sel ? b1 : b0;
    sel_zero = ZCHK && (sel_b == '0);
  end
  // zpend marks a locally answered divide-by-zero; it waits one WAIT cycle so done trails ack
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ptr <= 1'b0;
      gnt <= 1'b0;
      zpend <= 1'b0;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      div_start <= 1'b0;
      div_a <= '0;
      div_b <= '0;
      quot_out <= '0;
      rem_out <= '0;
      err_out <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      div_start <= 1'b0;
      case (state)
        IDLE: if (req0 || req1) begin
          gnt <= sel;
          ptr <= ~sel;
          ack0 <= ~sel;
          ack1 <= sel;
          div_start <= ~sel_zero;
          zpend <= sel_zero;
          div_a <= sel_a;
          div_b <= sel_b;
          state <= WAIT;
        end
        WAIT: if (zpend || (div_done && !div_start)) begin
          quot_out <= zpend ? '1 : div_quotient;
          rem_out <= zpend ? div_a : div_remainder;
          err_out <= zpend;
          done0 <= ~gnt;
          done1 <= gnt;
          zpend <= 1'b0;
          state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_div_share_arbiter.sv
// tb_div_share_arbiter: directed scoreboard bench for div_share_arbiter with a behavioural divider.
module tb_div_share_arbiter;
`ifdef DIV_ZERO_CHECK_EN
  localparam bit ZC = 1'b1;
`else
  localparam bit ZC = 1'b0;
`endif
  localparam int LAT = 3;
  typedef struct packed {logic r; logic [7:0] a, b; logic st;} ack_t;
  typedef struct packed {logic r; logic [7:0] q, rm; logic e, z;} done_t;
  logic clk = 1'b0, rst_n = 1'b0, req0 = 1'b0, req1 = 1'b0;
  logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic ack0, ack1, done0, done1, err_out, div_start, div_busy, div_done;
  logic [7:0] quot_out, rem_out, div_a, div_b, div_quotient, div_remainder;
  logic [7:0] mq, mr;
  logic dd, glitch = 1'b0, hold = 1'b0;
  int cnt, tests = 0, fails = 0, cyc = 0, ndone = 0, ack_cyc = 0, done_cyc = -100;
  bit busy_op = 1'b0, cap_prev = 1'b0, ack_prev = 1'b0, done_prev = 1'b0;
  logic [7:0] la, lb;
  ack_t exp_ack[$];
  done_t exp_done[$];

  div_share_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .quot_out(quot_out), .rem_out(rem_out), .err_out(err_out),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_busy(div_busy), .div_done(div_done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_div(input logic signed [7:0] a, input logic signed [7:0] b);
    if (b == 0) return {8'hFF, a};
    return {8'(a / b), 8'(a % b)};
  endfunction

  // divider model: result computed from div_a/div_b at completion, LAT cycles after start
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= 0; dd <= 1'b0; div_busy <= 1'b0; mq <= '0; mr <= '0;
    end else begin
      dd <= 1'b0;
      if (div_start) begin
        cnt <= LAT; div_busy <= 1'b1;
      end else if (cnt == 1) begin
        cnt <= 0; div_busy <= 1'b0; dd <= 1'b1; {mq, mr} <= ref_div(div_a, div_b);
      end else if (cnt > 1) cnt <= cnt - 1;
    end
  assign div_done = dd | (glitch && div_start);
  assign div_quotient = (glitch && div_start) ? 8'h55 : mq;
  assign div_remainder = (glitch && div_start) ? 8'hAA : mr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic r, input logic [7:0] a, b, q, rm);
    logic z;
    z = ZC && (b == 8'd0);
    exp_ack.push_back('{r: r, a: a, b: b, st: !z});
    exp_done.push_back('{r: r, q: q, rm: rm, e: z, z: z});
  endtask

  always @(negedge clk) begin
    ack_t e;
    done_t d;
    cyc++;
    if (!rst_n) begin
      busy_op = 1'b0; cap_prev = 1'b0; ack_prev = 1'b0; done_prev = 1'b0;
    end else begin
      chk("exclusive", {ack0 && ack1, done0 && done1, div_start && !(ack0 || ack1),
                        ack_prev && (ack0 || ack1), done_prev && (done0 || done1)}, 0);
      if (ack0 || ack1) begin
        if (exp_ack.size() == 0) chk("spurious_ack", {ack1, ack0}, 0);
        else begin
          e = exp_ack.pop_front();
          chk("ack_who", ack1, e.r);
          chk("div_a", div_a, e.a);
          chk("div_b", div_b, e.b);
          chk("div_start", div_start, e.st);
          chk("overlap", busy_op, 0);
          chk("resp_gap", cyc - done_cyc >= 2, 1);
        end
        busy_op = 1'b1; ack_cyc = cyc; la = div_a; lb = div_b;
      end
      if (done0 || done1) begin
        if (exp_done.size() == 0) chk("spurious_done", {done1, done0}, 0);
        else begin
          d = exp_done.pop_front();
          chk("done_who", done1, d.r);
          chk("quot_out", quot_out, d.q);
          chk("rem_out", rem_out, d.rm);
          chk("err_out", err_out, d.e);
          chk("hold_ab", {div_a, div_b}, {la, lb});
          if (d.z) chk("zero_latency", cyc - ack_cyc, 1);
          else chk("capture_timing", cap_prev, 1);
        end
        busy_op = 1'b0; done_cyc = cyc; ndone++;
      end
      cap_prev = div_done && !div_start;
      ack_prev = ack0 || ack1;
      done_prev = done0 || done1;
    end
  end

  task automatic step();
    @(negedge clk); #1;
    if (ack0 && !hold) req0 = 1'b0;
    if (ack1 && !hold) req1 = 1'b0;
  endtask

  task automatic run(input int n);
    int target;
    target = ndone + n;
    for (int i = 0; i < 300 && ndone < target; i++) step();
    chk("timeout", ndone >= target, 1);
  endtask

  initial begin
    repeat (3) step();
    chk("reset_outputs", {ack0, ack1, done0, done1, div_start, err_out, div_a, div_b, quot_out, rem_out}, 0);
    rst_n = 1'b1;
    step();
    // single requester, then idle must not disturb registers
    a0 = 8'd13; b0 = 8'd3; req0 = 1'b1; push(0, 13, 3, 4, 1);
    run(1);
    repeat (5) step();
    chk("idle_hold", {div_a, div_b, quot_out, rem_out}, {8'd13, 8'd3, 8'd4, 8'd1});
    // reset dropped in WAIT: pointer was 1 here, so the next tie must favour requester 0
    a0 = 8'd50; b0 = 8'd7; req0 = 1'b1; push(0, 50, 7, 7, 1);
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1 chk("reset_mid_wait", {ack0, ack1, done0, done1, div_start, err_out, div_a, div_b, quot_out, rem_out}, 0);
    exp_ack.delete(); exp_done.delete(); req0 = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (6) step();
    a0 = 8'd20; b0 = -8'sd4; a1 = -8'sd21; b1 = -8'sd7; req0 = 1'b1; req1 = 1'b1;
    push(0, 20, -8'sd4, -8'sd5, 0); push(1, -8'sd21, -8'sd7, 3, 0);
    run(2);
    // both held with a spurious div_done in every start cycle: strict alternation 0,1,0,1
    a0 = 8'd100; b0 = 8'd9; a1 = -8'sd50; b1 = 8'd6; glitch = 1'b1; hold = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    push(0, 100, 9, 11, 1); push(1, -8'sd50, 6, -8'sd8, -8'sd2);
    push(0, 100, 9, 11, 1); push(1, -8'sd50, 6, -8'sd8, -8'sd2);
    run(4);
    req0 = 1'b0; req1 = 1'b0; hold = 1'b0; glitch = 1'b0;
    repeat (3) step();
    // req1 arrives while requester 0 is in WAIT
    a0 = -8'sd13; b0 = 8'd4; req0 = 1'b1; push(0, -8'sd13, 4, -8'sd3, -8'sd1);
    repeat (3) step();
    a1 = 8'd9; b1 = -8'sd2; req1 = 1'b1; push(1, 9, -8'sd2, -8'sd4, 1);
    run(2);
    repeat (2) step();
    a0 = 8'd5; b0 = 8'd0; req0 = 1'b1; push(0, 5, 0, 8'hFF, 5);
    run(1);
    repeat (2) step();
    a1 = 8'd127; b1 = 8'd10; req1 = 1'b1; push(1, 127, 10, 12, 7);
    run(1);
    repeat (5) step();
    chk("queues_drained", {32'(exp_ack.size()), 32'(exp_done.size())}, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
